// File: rtl/afu_rd_dma_pkg.sv
// Shared types for the AFU read-DMA slice: line address, line payload and FSM state.
package afu_rd_dma_pkg;

  typedef logic [41:0]  line_addr_t;
  typedef logic [511:0] line_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } dma_state_t;

endpackage

// File: rtl/afu_rd_dma_sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count.
module afu_sync_fifo #(
  parameter int WIDTH = 512,
  parameter int DEPTH = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       valid,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  // Storage needs no reset; valid is derived from count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign valid = (count != '0);

endmodule

// File: rtl/afu_rd_dma.sv
// Streams num_lines cache lines from base_addr through the c0 read channel into a FWFT buffer.
//   state    | meaning
//   ST_IDLE  | waiting for start; zero-length jobs complete here
//   ST_ISSUE | issuing read requests, gated by almost-full and buffer credit
//   ST_DRAIN | all requests out; waiting for responses to leave the buffer
module afu_rd_dma
  import afu_rd_dma_pkg::*;
#(
  parameter int FIFO_DEPTH = 64,
  parameter int LEN_W      = 32
) (
  input  logic             clk,
  input  logic             spl_reset,
  input  logic             start,
  input  logic [41:0]      base_addr,
  input  logic [LEN_W-1:0] num_lines,
  output logic             busy,
  output logic             done,
  output logic             err,
  input  logic             spl_tx_rd_almostfull,
  output logic             afu_tx_rd_valid,
  output logic [41:0]      afu_tx_rd_addr,
  output logic [15:0]      afu_tx_rd_mdata,
  input  logic             spl_rx_rd_valid,
  input  logic [15:0]      spl_rx_rd_mdata,
  input  logic [511:0]     spl_rx_data,
  output logic             out_valid,
  output logic [511:0]     out_data,
  input  logic             out_ready
);

  localparam int CW  = LEN_W + 1;
  localparam int FAW = $clog2(FIFO_DEPTH);

  dma_state_t       state, state_nxt;
  line_addr_t       base_q;
  logic [LEN_W-1:0] len_q;
  logic [CW-1:0]    len_ext;
  logic [CW-1:0]    req_cnt, rsp_cnt;
  logic [CW-1:0]    outstanding, credit_used;
  logic [FAW:0]     fifo_count;
  logic             fifo_valid;
  line_t            fifo_dout;
  logic             push, pop, issue, done_nxt, latch_job;

  assign len_ext     = {1'b0, len_q};
  assign outstanding = req_cnt - rsp_cnt;
  assign credit_used = outstanding + CW'(fifo_count);

  // Credit counts requests from the moment they are decided, so the buffer can never overflow.
  assign issue = (state == ST_ISSUE) && (req_cnt != len_ext) && !spl_tx_rd_almostfull
                 && (credit_used < CW'(FIFO_DEPTH));
  assign push  = spl_rx_rd_valid && (state != ST_IDLE);
  assign pop   = fifo_valid && out_ready;

  always_ff @(posedge clk) begin
    if (spl_reset) state <= ST_IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    latch_job = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (num_lines == '0) begin
            done_nxt = 1'b1;
          end else begin
            latch_job = 1'b1;
            state_nxt = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (req_cnt == len_ext) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if ((rsp_cnt == len_ext) && !fifo_valid) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (spl_reset) begin
      base_q          <= '0;
      len_q           <= '0;
      req_cnt         <= '0;
      rsp_cnt         <= '0;
      err             <= 1'b0;
      done            <= 1'b0;
      afu_tx_rd_valid <= 1'b0;
      afu_tx_rd_addr  <= '0;
      afu_tx_rd_mdata <= '0;
    end else begin
      done            <= done_nxt;
      afu_tx_rd_valid <= issue;
      if (latch_job) begin
        base_q  <= base_addr;
        len_q   <= num_lines;
        req_cnt <= '0;
        rsp_cnt <= '0;
      end else begin
        if (issue) begin
          req_cnt         <= req_cnt + 1'b1;
          afu_tx_rd_addr  <= base_q + 42'(req_cnt);
          afu_tx_rd_mdata <= 16'(req_cnt);
        end
        if (push) begin
          rsp_cnt <= rsp_cnt + 1'b1;
          if (spl_rx_rd_mdata != 16'(rsp_cnt)) err <= 1'b1;
        end
      end
    end
  end

  afu_sync_fifo #(
    .WIDTH (512),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (spl_reset),
    .push  (push),
    .din   (spl_rx_data),
    .pop   (pop),
    .dout  (fifo_dout),
    .valid (fifo_valid),
    .count (fifo_count)
  );

  assign busy      = (state != ST_IDLE);
  assign out_valid = fifo_valid;
  assign out_data  = fifo_dout;

endmodule

// File: tb/tb_afu_rd_dma.sv
// Scoreboard bench: two instances (deep and 4-entry buffer) share request/data expectation queues.
module tb_afu_rd_dma;

  localparam int LEN_W = 32;

  typedef struct packed {
    logic [41:0] addr;
    logic [15:0] mdata;
  } req_t;

  typedef struct {
    int          inst;
    int          due;
    logic [41:0] addr;
    logic [15:0] mdata;
  } rsp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst        [2];
  logic              start      [2];
  logic [41:0]       base_addr  [2];
  logic [LEN_W-1:0]  num_lines  [2];
  logic              busy       [2];
  logic              done       [2];
  logic              err        [2];
  logic              almostfull [2];
  logic              tx_valid   [2];
  logic [41:0]       tx_addr    [2];
  logic [15:0]       tx_mdata   [2];
  logic              rx_valid   [2];
  logic [15:0]       rx_mdata   [2];
  logic [511:0]      rx_data    [2];
  logic              out_valid  [2];
  logic [511:0]      out_data   [2];
  logic              out_ready  [2];

  afu_rd_dma #(.FIFO_DEPTH(64), .LEN_W(LEN_W)) dut0 (
    .clk(clk), .spl_reset(rst[0]), .start(start[0]), .base_addr(base_addr[0]),
    .num_lines(num_lines[0]), .busy(busy[0]), .done(done[0]), .err(err[0]),
    .spl_tx_rd_almostfull(almostfull[0]), .afu_tx_rd_valid(tx_valid[0]),
    .afu_tx_rd_addr(tx_addr[0]), .afu_tx_rd_mdata(tx_mdata[0]),
    .spl_rx_rd_valid(rx_valid[0]), .spl_rx_rd_mdata(rx_mdata[0]), .spl_rx_data(rx_data[0]),
    .out_valid(out_valid[0]), .out_data(out_data[0]), .out_ready(out_ready[0]));

  afu_rd_dma #(.FIFO_DEPTH(4), .LEN_W(LEN_W)) dut1 (
    .clk(clk), .spl_reset(rst[1]), .start(start[1]), .base_addr(base_addr[1]),
    .num_lines(num_lines[1]), .busy(busy[1]), .done(done[1]), .err(err[1]),
    .spl_tx_rd_almostfull(almostfull[1]), .afu_tx_rd_valid(tx_valid[1]),
    .afu_tx_rd_addr(tx_addr[1]), .afu_tx_rd_mdata(tx_mdata[1]),
    .spl_rx_rd_valid(rx_valid[1]), .spl_rx_rd_mdata(rx_mdata[1]), .spl_rx_data(rx_data[1]),
    .out_valid(out_valid[1]), .out_data(out_data[1]), .out_ready(out_ready[1]));

  int     checks = 0;
  int     errors = 0;
  req_t   exp_req [$];
  logic [511:0] exp_out [$];
  rsp_t   pipe [$];
  int     job_reqs = 0;
  int     job_outs = 0;
  int     first_req_cyc = 0;
  int     last_req_cyc = 0;
  int     pcyc = 0;
  int     rcyc = 0;
  logic   af_at_edge [2];
  logic   bad_en = 1'b0;

  function automatic logic [511:0] line_data(input logic [41:0] a);
    return {8'h5A, {12{a}}};
  endfunction

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    pcyc++;
    for (int i = 0; i < 2; i++) af_at_edge[i] = almostfull[i];
  end

  // Read-channel model: every observed request is answered 3 cycles later, in order.
  always @(negedge clk) begin
    rsp_t e;
    rcyc++;
    for (int i = 0; i < 2; i++) rx_valid[i] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (tx_valid[i] === 1'b1) begin
        e.inst = i; e.due = rcyc + 3; e.addr = tx_addr[i]; e.mdata = tx_mdata[i];
        pipe.push_back(e);
      end
    end
    if (pipe.size() > 0 && pipe[0].due <= rcyc) begin
      e = pipe.pop_front();
      rx_valid[e.inst] = 1'b1;
      rx_mdata[e.inst] = (bad_en && e.mdata == 16'd4) ? 16'd5 : e.mdata;
      rx_data[e.inst]  = line_data(e.addr);
    end
  end

  // Monitor: requests and output beats are compared against the expectation queues.
  always @(negedge clk) begin
    req_t r;
    for (int i = 0; i < 2; i++) begin
      if (tx_valid[i] === 1'b1) begin
        if (job_reqs == 0) first_req_cyc = pcyc;
        last_req_cyc = pcyc;
        job_reqs++;
        check("req_af_gate", af_at_edge[i], 1'b0);
        if (exp_req.size() == 0) begin
          check("req_extra", tx_addr[i], 512'h0 - 1);
        end else begin
          r = exp_req.pop_front();
          check("req_addr", tx_addr[i], r.addr);
          check("req_mdata", tx_mdata[i], r.mdata);
        end
      end
      if (out_valid[i] === 1'b1 && out_ready[i] === 1'b1) begin
        job_outs++;
        if (exp_out.size() == 0) check("out_extra", out_data[i], 512'h0 - 1);
        else check("out_data", out_data[i], exp_out.pop_front());
      end
    end
  end

  task automatic launch(input int i, input logic [41:0] b, input logic [LEN_W-1:0] n);
    req_t r;
    job_reqs = 0;
    job_outs = 0;
    @(posedge clk); #1;
    start[i] = 1'b1; base_addr[i] = b; num_lines[i] = n;
    for (int k = 0; k < int'(n); k++) begin
      r.addr = b + 42'(k);
      r.mdata = 16'(k);
      exp_req.push_back(r);
      exp_out.push_back(line_data(b + 42'(k)));
    end
    @(posedge clk); #1;
    start[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int budget);
    int n = 0;
    while (done[i] !== 1'b1 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("done_seen", done[i], 1'b1);
    check("busy_at_done", busy[i], 1'b0);
    check("req_queue_empty", exp_req.size(), 0);
    check("out_queue_empty", exp_out.size(), 0);
    @(posedge clk); #1;
    check("done_one_cycle", done[i], 1'b0);
  endtask

  task automatic pulse_reset(input int i);
    rst[i] = 1'b1;
    @(posedge clk); #1;
    rst[i] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; start[i] = 1'b0; base_addr[i] = '0; num_lines[i] = '0;
      almostfull[i] = 1'b0; out_ready[i] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) rst[i] = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 2; i++) begin
      check("rst_busy", busy[i], 1'b0);
      check("rst_done", done[i], 1'b0);
      check("rst_err", err[i], 1'b0);
      check("rst_tx_valid", tx_valid[i], 1'b0);
      check("rst_out_valid", out_valid[i], 1'b0);
      check("rst_tx_addr", tx_addr[i], 42'h0);
      check("rst_tx_mdata", tx_mdata[i], 16'h0);
    end

    // Nominal 8-line job.
    launch(0, 42'h100, 8);
    check("busy_after_start", busy[0], 1'b1);
    wait_done(0, 100);
    check("nom_req_count", job_reqs, 8);
    check("nom_out_count", job_outs, 8);
    check("nom_back_to_back", last_req_cyc - first_req_cyc, 7);
    check("nom_err", err[0], 1'b0);

    // Zero-length job.
    launch(0, 42'h50, 0);
    check("zero_done", done[0], 1'b1);
    check("zero_busy", busy[0], 1'b0);
    @(posedge clk); #1;
    check("zero_done_width", done[0], 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("zero_req_count", job_reqs, 0);

    // Second start while busy must be ignored.
    launch(0, 42'h200, 8);
    @(posedge clk); #1;
    start[0] = 1'b1; base_addr[0] = 42'h900; num_lines[0] = 5;
    @(posedge clk); #1;
    start[0] = 1'b0;
    wait_done(0, 100);
    check("busy_start_reqs", job_reqs, 8);

    // Almost-full high for cycles 3..9 of a 16-line job.
    launch(0, 42'h700, 16);
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk); #1;
      almostfull[0] = (c >= 3 && c <= 9);
    end
    almostfull[0] = 1'b0;
    wait_done(0, 100);
    check("af_req_count", job_reqs, 16);
    check("af_out_count", job_outs, 16);

    // Tag error: response tag 4 replaced by 5.
    bad_en = 1'b1;
    launch(0, 42'h300, 8);
    wait_done(0, 100);
    bad_en = 1'b0;
    check("tag_err_set", err[0], 1'b1);
    check("tag_out_count", job_outs, 8);
    launch(0, 42'h380, 2);
    wait_done(0, 100);
    check("tag_err_sticky", err[0], 1'b1);
    pulse_reset(0);
    check("tag_err_cleared", err[0], 1'b0);

    // Mid-job reset after the third request.
    launch(0, 42'h400, 8);
    n = 0;
    while (!(tx_valid[0] === 1'b1 && job_reqs == 2) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    rst[0] = 1'b1;
    @(posedge clk); #1;
    rst[0] = 1'b0;
    check("mrst_busy", busy[0], 1'b0);
    check("mrst_tx_valid", tx_valid[0], 1'b0);
    check("mrst_out_valid", out_valid[0], 1'b0);
    exp_req.delete();
    exp_out.delete();
    repeat (12) @(posedge clk);
    #1;
    check("mrst_req_count", job_reqs, 3);
    check("mrst_no_stale_out", job_outs, 0);
    launch(0, 42'h500, 2);
    wait_done(0, 100);
    check("mrst_new_reqs", job_reqs, 2);
    check("mrst_new_outs", job_outs, 2);

    // Back-pressure on the 4-entry instance.
    out_ready[1] = 1'b0;
    launch(1, 42'h600, 10);
    repeat (30) @(posedge clk);
    #1;
    check("bp_stall_reqs", job_reqs, 4);
    check("bp_out_valid", out_valid[1], 1'b1);
    check("bp_busy", busy[1], 1'b1);
    out_ready[1] = 1'b1;
    wait_done(1, 200);
    check("bp_req_count", job_reqs, 10);
    check("bp_out_count", job_outs, 10);
    check("bp_err", err[1], 1'b0);

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
